// File: rtl/lsu_issue_queue.sv
// lsu_issue_queue: in-order memory-op queue feeding the load/store unit.
// Ops are held in a circular buffer until base (and, for stores, data)
// operands are ready, either at dispatch or via CDB snooping.  The head op
// issues with its effective address (base + offset) once ready and the LSU
// is not stalled.  Optional macro LSU_IQ_CDB_WAKE_ISSUE_EN lets the head
// issue in the same cycle its last operand appears on the CDB.
module lsu_issue_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic             disp_is_ld,
    input  logic [5:0]       disp_rob,
    input  logic [15:0]      disp_offset,
    input  logic             disp_base_rdy,
    input  logic [15:0]      disp_base,
    input  logic             disp_data_rdy,
    input  logic [15:0]      disp_data,
    input  logic             cdb_valid,
    input  logic [5:0]       cdb_tag,
    input  logic [15:0]      cdb_data,
    input  logic             load_stall,
    output logic             is_ld,
    output logic [15:0]      data,
    output logic [15:0]      location,
    output logic [5:0]       ROBloc,
    output logic             input_valid,
    output logic [PTR_W:0]   count
);

    // Queue control state
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;

    // Per-entry payload (ready bits only meaningful while the entry is valid)
    logic [DEPTH-1:0] ent_is_ld_q, ent_is_ld_d;
    logic [DEPTH-1:0] base_rdy_q, base_rdy_d;
    logic [DEPTH-1:0] data_rdy_q, data_rdy_d;
    logic [5:0]       ent_rob_q  [DEPTH];
    logic [5:0]       ent_rob_d  [DEPTH];
    logic [15:0]      ent_off_q  [DEPTH];
    logic [15:0]      ent_off_d  [DEPTH];
    logic [15:0]      ent_base_q [DEPTH];
    logic [15:0]      ent_base_d [DEPTH];
    logic [15:0]      ent_data_q [DEPTH];
    logic [15:0]      ent_data_d [DEPTH];

    // Registered LSU-facing outputs
    logic             out_valid_q, out_valid_d;
    logic             out_is_ld_q, out_is_ld_d;
    logic [15:0]      out_data_q, out_data_d;
    logic [15:0]      out_loc_q, out_loc_d;
    logic [5:0]       out_rob_q, out_rob_d;

    // CDB match per waiting operand
    logic [DEPTH-1:0] base_wake;
    logic [DEPTH-1:0] data_wake;

    // Dispatch-side signals
    logic             accept;
    logic             disp_base_hit;
    logic             disp_data_hit;

    // Head view used by the issue decision
    logic             head_valid;
    logic             head_is_ld;
    logic             head_base_rdy;
    logic             head_data_rdy;
    logic [15:0]      head_base;
    logic [15:0]      head_data;
    logic             issue;

    assign disp_ready = (count_q != (PTR_W+1)'(DEPTH));
    assign accept     = disp_valid && disp_ready;

    // An operand that is not ready carries its producer's ROB tag in [5:0]
    assign disp_base_hit = cdb_valid && (disp_base[5:0] == cdb_tag);
    assign disp_data_hit = cdb_valid && (disp_data[5:0] == cdb_tag);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wake
            assign base_wake[gi] = cdb_valid && valid_q[gi] && !base_rdy_q[gi]
                                   && (ent_base_q[gi][5:0] == cdb_tag);
            assign data_wake[gi] = cdb_valid && valid_q[gi] && !data_rdy_q[gi]
                                   && (ent_data_q[gi][5:0] == cdb_tag);
        end
    endgenerate

    // Head operand view, optionally bypassing a same-cycle CDB result
    always_comb begin
        head_valid = valid_q[head_q];
        head_is_ld = ent_is_ld_q[head_q];
`ifdef LSU_IQ_CDB_WAKE_ISSUE_EN
        head_base_rdy = base_rdy_q[head_q] || base_wake[head_q];
        head_data_rdy = data_rdy_q[head_q] || data_wake[head_q];
        head_base     = base_rdy_q[head_q] ? ent_base_q[head_q] : cdb_data;
        head_data     = data_rdy_q[head_q] ? ent_data_q[head_q] : cdb_data;
`else
        head_base_rdy = base_rdy_q[head_q];
        head_data_rdy = data_rdy_q[head_q];
        head_base     = ent_base_q[head_q];
        head_data     = ent_data_q[head_q];
`endif
        issue = head_valid && head_base_rdy && (head_is_ld || head_data_rdy)
                && !load_stall;
    end

    // Pointer, count and valid-bit next state
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (issue) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (accept) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        case ({accept, issue})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Entry payload next state: CDB wakeup, then dispatch write at tail
    always_comb begin
        ent_is_ld_d = ent_is_ld_q;
        base_rdy_d  = base_rdy_q;
        data_rdy_d  = data_rdy_q;
        ent_rob_d   = ent_rob_q;
        ent_off_d   = ent_off_q;
        ent_base_d  = ent_base_q;
        ent_data_d  = ent_data_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (base_wake[i]) begin
                base_rdy_d[i] = 1'b1;
                ent_base_d[i] = cdb_data;
            end
            if (data_wake[i]) begin
                data_rdy_d[i] = 1'b1;
                ent_data_d[i] = cdb_data;
            end
        end
        if (accept) begin
            ent_is_ld_d[tail_q] = disp_is_ld;
            ent_rob_d[tail_q]   = disp_rob;
            ent_off_d[tail_q]   = disp_offset;
            if (disp_base_rdy) begin
                base_rdy_d[tail_q] = 1'b1;
                ent_base_d[tail_q] = disp_base;
            end else if (disp_base_hit) begin
                base_rdy_d[tail_q] = 1'b1;
                ent_base_d[tail_q] = cdb_data;
            end else begin
                base_rdy_d[tail_q] = 1'b0;
                ent_base_d[tail_q] = disp_base;
            end
            // Loads never wait on store data
            if (disp_is_ld) begin
                data_rdy_d[tail_q] = 1'b1;
                ent_data_d[tail_q] = 16'h0000;
            end else if (disp_data_rdy) begin
                data_rdy_d[tail_q] = 1'b1;
                ent_data_d[tail_q] = disp_data;
            end else if (disp_data_hit) begin
                data_rdy_d[tail_q] = 1'b1;
                ent_data_d[tail_q] = cdb_data;
            end else begin
                data_rdy_d[tail_q] = 1'b0;
                ent_data_d[tail_q] = disp_data;
            end
        end
    end

    // Output register next state: load on issue, otherwise hold with valid low
    always_comb begin
        out_valid_d = issue;
        out_is_ld_d = out_is_ld_q;
        out_data_d  = out_data_q;
        out_loc_d   = out_loc_q;
        out_rob_d   = out_rob_q;
        if (issue) begin
            out_is_ld_d = head_is_ld;
            out_data_d  = head_is_ld ? 16'h0000 : head_data;
            out_loc_d   = head_base + ent_off_q[head_q];
            out_rob_d   = ent_rob_q[head_q];
        end
    end

    // Control and output registers; reset and flush both clear everything
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            out_valid_q <= 1'b0;
            out_is_ld_q <= 1'b0;
            out_data_q  <= '0;
            out_loc_q   <= '0;
            out_rob_q   <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            out_valid_q <= out_valid_d;
            out_is_ld_q <= out_is_ld_d;
            out_data_q  <= out_data_d;
            out_loc_q   <= out_loc_d;
            out_rob_q   <= out_rob_d;
        end
    end

    // Entry payload storage; contents are don't-care while the valid bit is low
    always_ff @(posedge clk) begin
        ent_is_ld_q <= ent_is_ld_d;
        base_rdy_q  <= base_rdy_d;
        data_rdy_q  <= data_rdy_d;
        ent_rob_q   <= ent_rob_d;
        ent_off_q   <= ent_off_d;
        ent_base_q  <= ent_base_d;
        ent_data_q  <= ent_data_d;
    end

    assign input_valid = out_valid_q;
    assign is_ld       = out_is_ld_q;
    assign data        = out_data_q;
    assign location    = out_loc_q;
    assign ROBloc      = out_rob_q;
    assign count       = count_q;

endmodule

// File: tb/tb_lsu_issue_queue.sv
// Testbench for lsu_issue_queue: queue-of-ops reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_lsu_issue_queue;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        disp_valid, disp_ready, disp_is_ld;
    logic [5:0]  disp_rob;
    logic [15:0] disp_offset, disp_base, disp_data;
    logic        disp_base_rdy, disp_data_rdy;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        load_stall;
    logic        is_ld, input_valid;
    logic [15:0] data, location;
    logic [5:0]  ROBloc;
    logic [PTR_W:0] count;

    lsu_issue_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_is_ld(disp_is_ld), .disp_rob(disp_rob), .disp_offset(disp_offset),
        .disp_base_rdy(disp_base_rdy), .disp_base(disp_base),
        .disp_data_rdy(disp_data_rdy), .disp_data(disp_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .load_stall(load_stall),
        .is_ld(is_ld), .data(data), .location(location), .ROBloc(ROBloc),
        .input_valid(input_valid), .count(count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        ld;
        logic [5:0]  rob;
        logic [15:0] off;
        logic        brdy;
        logic [15:0] base;
        logic        drdy;
        logic [15:0] dat;
    } op_t;

    op_t         mq[$];
    bit          model_live = 0;
    logic        exp_valid = 0, exp_ld = 0;
    logic [15:0] exp_data = 0, exp_loc = 0;
    logic [5:0]  exp_rob = 0;

    task automatic model_step();
        bit   can_accept;
        bit   do_issue;
        op_t  h;
        op_t  n;
        if (reset || flush) begin
            mq.delete();
            exp_valid = 0; exp_ld = 0; exp_data = 0; exp_loc = 0; exp_rob = 0;
            model_live = 1;
            return;
        end
        can_accept = disp_valid && (mq.size() != DEPTH);
        do_issue = 0;
        if (mq.size() > 0 && !load_stall) begin
            h = mq[0];
`ifdef LSU_IQ_CDB_WAKE_ISSUE_EN
            if (!h.brdy && cdb_valid && cdb_tag == h.base[5:0]) begin h.brdy = 1; h.base = cdb_data; end
            if (!h.drdy && cdb_valid && cdb_tag == h.dat[5:0])  begin h.drdy = 1; h.dat  = cdb_data; end
`endif
            do_issue = h.brdy && (h.ld || h.drdy);
        end
        foreach (mq[i]) begin
            if (!mq[i].brdy && cdb_valid && cdb_tag == mq[i].base[5:0]) begin mq[i].brdy = 1; mq[i].base = cdb_data; end
            if (!mq[i].drdy && cdb_valid && cdb_tag == mq[i].dat[5:0])  begin mq[i].drdy = 1; mq[i].dat  = cdb_data; end
        end
        if (do_issue) begin
            exp_valid = 1;
            exp_ld    = h.ld;
            exp_data  = h.ld ? 16'h0 : h.dat;
            exp_loc   = h.base + h.off;
            exp_rob   = h.rob;
            void'(mq.pop_front());
        end else begin
            exp_valid = 0;
        end
        if (can_accept) begin
            n.ld   = disp_is_ld;
            n.rob  = disp_rob;
            n.off  = disp_offset;
            n.brdy = disp_base_rdy || (cdb_valid && cdb_tag == disp_base[5:0]);
            n.base = disp_base_rdy ? disp_base : (n.brdy ? cdb_data : disp_base);
            n.drdy = disp_is_ld || disp_data_rdy || (cdb_valid && cdb_tag == disp_data[5:0]);
            n.dat  = (disp_is_ld || disp_data_rdy) ? disp_data : (n.drdy ? cdb_data : disp_data);
            mq.push_back(n);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Single compare process, away from the active edge
    initial forever begin
        @(negedge clk);
        if (model_live) begin
            chk("input_valid", 32'(input_valid), 32'(exp_valid));
            chk("is_ld",       32'(is_ld),       32'(exp_ld));
            chk("data",        32'(data),        32'(exp_data));
            chk("location",    32'(location),    32'(exp_loc));
            chk("ROBloc",      32'(ROBloc),      32'(exp_rob));
            chk("count",       32'(count),       32'(mq.size()));
            chk("disp_ready",  32'(disp_ready),  32'(mq.size() != DEPTH));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        disp_valid = 0; disp_is_ld = 0; disp_rob = 0; disp_offset = 0;
        disp_base_rdy = 0; disp_base = 0; disp_data_rdy = 0; disp_data = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
    endtask

    task automatic set_op(input logic ld, input logic [5:0] rob, input logic [15:0] off,
                          input logic brdy, input logic [15:0] base,
                          input logic drdy, input logic [15:0] dat);
        disp_valid = 1; disp_is_ld = ld; disp_rob = rob; disp_offset = off;
        disp_base_rdy = brdy; disp_base = base; disp_data_rdy = drdy; disp_data = dat;
    endtask

    // Wait (bounded) until an issue pulse is visible on the outputs
    task automatic wait_issue(input string name);
        int n = 0;
        while (input_valid !== 1'b1 && n < 30) begin
            cyc();
            n++;
        end
        if (input_valid !== 1'b1) begin
            tests++; fails++;
            $display("FAIL %s: no issue pulse within %0d cycles", name, n);
        end
    endtask

    initial begin
        reset = 1; flush = 0; load_stall = 0;
        idle_inputs();
        cyc(); cyc();
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_ready", 32'(disp_ready), 32'd1);
        chk("reset_valid", 32'(input_valid), 32'd0);
        reset = 0;
        cyc();

        // Ready load into an empty queue
        set_op(1, 6'd5, 16'h0010, 1, 16'h1000, 0, 16'h0);
        cyc();
        idle_inputs();
        cyc();
        chk("t1_valid", 32'(input_valid), 32'd1);
        chk("t1_is_ld", 32'(is_ld), 32'd1);
        chk("t1_loc",   32'(location), 32'h1010);
        chk("t1_rob",   32'(ROBloc), 32'd5);
        cyc();
        chk("t1_pulse_end", 32'(input_valid), 32'd0);
        $display("[TB] txn ready-load rob=5 loc=%h", location);

        // Store waiting on CDB for its data
        set_op(0, 6'd7, 16'h0004, 1, 16'h2000, 0, 16'h0009);
        cyc();
        idle_inputs();
        cyc(); cyc();
        chk("t2_wait", 32'(input_valid), 32'd0);
        cdb_valid = 1; cdb_tag = 6'd9; cdb_data = 16'hBEEF;
        cyc();
        idle_inputs();
`ifndef LSU_IQ_CDB_WAKE_ISSUE_EN
        chk("t2_not_yet", 32'(input_valid), 32'd0);
        cyc();
`endif
        chk("t2_valid", 32'(input_valid), 32'd1);
        chk("t2_loc",   32'(location), 32'h2004);
        chk("t2_data",  32'(data), 32'hBEEF);
        chk("t2_is_ld", 32'(is_ld), 32'd0);
        $display("[TB] txn store-cdb rob=7 loc=%h data=%h", location, data);
        cyc();

        // In-order blocking: A waits on tag 3, B is ready
        set_op(1, 6'd1, 16'h0000, 0, 16'h0003, 0, 16'h0);
        cyc();
        set_op(1, 6'd2, 16'h0008, 1, 16'h0200, 0, 16'h0);
        cyc();
        idle_inputs();
        cyc(); cyc();
        chk("t3_blocked", 32'(input_valid), 32'd0);
        chk("t3_count",   32'(count), 32'd2);
        cdb_valid = 1; cdb_tag = 6'd3; cdb_data = 16'h0100;
        cyc();
        idle_inputs();
        wait_issue("t3_a");
        chk("t3_a_rob", 32'(ROBloc), 32'd1);
        chk("t3_a_loc", 32'(location), 32'h0100);
        cyc();
        chk("t3_b_valid", 32'(input_valid), 32'd1);
        chk("t3_b_rob",   32'(ROBloc), 32'd2);
        chk("t3_b_loc",   32'(location), 32'h0208);
        $display("[TB] txn in-order A then B loc=%h", location);
        cyc();

        // Fill under stall, overflow attempt, then drain in order
        load_stall = 1;
        for (int i = 0; i < DEPTH; i++) begin
            set_op(0, 6'(10 + i), 16'(i), 1, 16'h3000, 1, 16'(16'hA000 + i));
            cyc();
        end
        chk("t4_full_ready", 32'(disp_ready), 32'd0);
        chk("t4_full_count", 32'(count), 32'd8);
        set_op(1, 6'd30, 16'h0, 1, 16'h0, 0, 16'h0);
        cyc();
        idle_inputs();
        chk("t4_overflow_count", 32'(count), 32'd8);
        load_stall = 0;
        for (int i = 0; i < DEPTH; i++) begin
            cyc();
            chk("t4_drain_valid", 32'(input_valid), 32'd1);
            chk("t4_drain_rob",   32'(ROBloc), 32'(10 + i));
            $display("[TB] txn drain rob=%0d loc=%h data=%h", ROBloc, location, data);
        end
        cyc();
        chk("t4_empty", 32'(count), 32'd0);

        // Wrap through the pointers plus 16-bit address overflow
        for (int i = 0; i < 12; i++) begin
            load_stall = (i < 6);
            if (i == 11) set_op(1, 6'd31, 16'h0002, 1, 16'hFFFF, 0, 16'h0);
            else         set_op(0, 6'(20 + i), 16'h0001, 1, 16'(i * 16'h100), 1, 16'(i));
            cyc();
        end
        idle_inputs();
        load_stall = 0;
        begin
            int n = 0;
            while (!(input_valid === 1'b1 && ROBloc === 6'd31) && n < 30) begin
                cyc();
                n++;
            end
            chk("t5_wrap_rob", 32'(ROBloc), 32'd31);
            chk("t5_wrap_loc", 32'(location), 32'h0001);
            $display("[TB] txn wrap rob=%0d loc=%h", ROBloc, location);
        end
        cyc(); cyc();

        // Flush with pending ops plus same-cycle dispatch and CDB
        load_stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_op(1, 6'(40 + i), 16'h0, 1, 16'h0500, 0, 16'h0);
            cyc();
        end
        flush = 1;
        set_op(0, 6'd50, 16'h0, 0, 16'h0004, 0, 16'h0004);
        cdb_valid = 1; cdb_tag = 6'd4; cdb_data = 16'h1234;
        cyc();
        flush = 0; load_stall = 0;
        idle_inputs();
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_valid", 32'(input_valid), 32'd0);
        chk("t6_ready", 32'(disp_ready), 32'd1);
        set_op(1, 6'd44, 16'h0001, 1, 16'h0040, 0, 16'h0);
        cyc();
        idle_inputs();
        cyc();
        chk("t6_after_valid", 32'(input_valid), 32'd1);
        chk("t6_after_rob",   32'(ROBloc), 32'd44);
        chk("t6_after_loc",   32'(location), 32'h0041);
        $display("[TB] txn post-flush rob=%0d loc=%h", ROBloc, location);
        cyc();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            disp_valid    = ($urandom_range(0, 1) == 1);
            disp_is_ld    = ($urandom_range(0, 1) == 1);
            disp_rob      = 6'($urandom_range(0, 63));
            disp_offset   = 16'($urandom);
            disp_base_rdy = ($urandom_range(0, 2) != 0);
            disp_base     = disp_base_rdy ? 16'($urandom) : 16'($urandom_range(0, 7));
            disp_data_rdy = ($urandom_range(0, 2) != 0);
            disp_data     = disp_data_rdy ? 16'($urandom) : 16'($urandom_range(0, 7));
            cdb_valid     = ($urandom_range(0, 2) == 0);
            cdb_tag       = 6'($urandom_range(0, 7));
            cdb_data      = 16'($urandom);
            load_stall    = ($urandom_range(0, 3) == 0);
            flush         = ($urandom_range(0, 99) == 0);
            reset         = ($urandom_range(0, 499) == 0);
            cyc();
            if (input_valid === 1'b1)
                $display("[TB] txn rnd rob=%0d ld=%0d loc=%h data=%h", ROBloc, is_ld, location, data);
        end
        idle_inputs();
        flush = 0; reset = 0; load_stall = 0;
        for (int i = 0; i < 4; i++) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsu_issue_queue.md
Name: lsu_issue_queue

Overview:
- In-order memory-op queue directly upstream of the load/store unit.
- Accepts loads/stores from dispatch and holds them until their operands are ready. Operands arrive either with the op or by snooping the common data bus (CDB).
- Computes the effective address (base + offset) and issues one op per cycle, in program order, to the LSU.
- Honours the LSU's load_stall back-pressure and drops all state on flush.

Parameters:
DEPTH, 8, number of queue entries (power of 2, >= 2)
PTR_W, 3, log2(DEPTH)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high; clears queue and outputs
flush  input  1  pipeline flush (mispredict); synchronous, same effect as reset
disp_valid  input  1  dispatch presents a memory op
disp_ready  output  1  queue can accept this cycle (count < DEPTH)
disp_is_ld  input  1  1 = load, 0 = store
disp_rob  input  6  ROB index of the op
disp_offset  input  16  immediate offset
disp_base_rdy  input  1  base operand value valid
disp_base  input  16  base value, or ROB tag in [5:0] when not ready
disp_data_rdy  input  1  store-data value valid (ignored for loads)
disp_data  input  16  store data, or ROB tag in [5:0] when not ready
cdb_valid  input  1  broadcast valid
cdb_tag  input  6  ROB tag being broadcast
cdb_data  input  16  broadcast value
load_stall  input  1  LSU cannot accept; hold issue
is_ld  output  1  to LSU
data  output  16  store data to LSU (0 for loads)
location  output  16  effective address
ROBloc  output  6  ROB index
input_valid  output  1  one-cycle issue pulse to LSU
count  output  PTR_W+1  occupied entries (debug/perf)

Behaviour:
- Reset or flush (reset has priority; both act the same):
  - head, tail and count go to 0; all entry valid bits clear.
  - input_valid=0; is_ld, data, location and ROBloc go to 0.
  - disp_ready=1 from the next cycle.
  - A dispatch or CDB in the same cycle is discarded.
- Storage is a circular buffer. Pointers wrap modulo DEPTH. count is tracked separately, so full and empty are unambiguous.
- Dispatch accept:
  - An op is accepted when disp_valid && disp_ready. It is written at tail, and tail advances.
  - disp_ready = (count != DEPTH). It depends on registered state only, so it does not depend on issue in the same cycle.
- Operand wakeup, per non-ready operand of each valid entry:
  - If cdb_valid && cdb_tag == stored tag, the value becomes cdb_data and the ready bit is set next cycle.
  - Dispatch-cycle check: a dispatched operand whose tag matches the CDB in the same cycle is captured as ready with cdb_data.
  - Loads are treated as data-ready at dispatch.
- Issue condition, evaluated on registered state: head valid && base_rdy && (is_ld || data_rdy) && !load_stall.
  - Issue is strictly in order. A non-ready head blocks younger ready entries.
  - On issue, at the next posedge: the output registers load {is_ld, data, base+offset, rob}, input_valid=1, the head entry is invalidated, and head advances.
  - Latency: a head that becomes ready at cycle N appears on the outputs at cycle N+1.
  - When not issuing, input_valid=0 and the other outputs hold their last values.
- Address arithmetic: 16-bit unsigned add, carry discarded (0xFFFF+0x0002=0x0001).
- Store data output is the 16-bit data value. For loads, data=0.
- Count updates:
  - Dispatch and issue in the same cycle: count unchanged; head and tail both advance.
  - Empty queue: no issue, even if disp_valid that cycle.
  - At count==DEPTH-1, one dispatch with no issue raises full.
- load_stall only freezes issue. Dispatch and wakeup continue.

Optional Feature:
Macro: LSU_IQ_CDB_WAKE_ISSUE_EN
- Defined:
  - The head may issue in the same cycle its last missing operand arrives on the CDB.
  - The issued address/data use cdb_data directly, via a bypass mux in front of the adder and data register.
  - Effective latency is CDB cycle N, output at N+1.
- Undefined: the head issues no earlier than the cycle after its ready bit is registered, so output appears at N+2 after the CDB.
- Functional results are identical either way; only timing changes.

Test Plan:
- Ready load, empty queue: dispatch ld, rob=5, base=0x1000, offset=0x0010 -> next cycle input_valid=1, is_ld=1, location=0x1010, ROBloc=5; input_valid returns to 0 the following cycle.
- Store waits on CDB: dispatch st, base ready 0x2000, offset 4, data tag 9 not ready. Then cdb_valid, tag 9, data 0xBEEF -> issue with location=0x2004, data=0xBEEF, is_ld=0. Issue lands 2 cycles after the CDB, or 1 cycle with LSU_IQ_CDB_WAKE_ISSUE_EN.
- In-order blocking: dispatch A (base tag 3, not ready), then B (fully ready). No issue until tag 3 broadcast with 0x0100 (offset 0) -> A issues with location=0x0100, then B issues the next cycle.
- Full/back-pressure: hold load_stall=1 and dispatch 8 ready ops -> disp_ready=0, count=8, 9th disp_valid ignored. Release stall -> 8 consecutive input_valid pulses with ROBloc in dispatch order.
- Wrap and overflow: dispatch/issue 12 ops through DEPTH=8 -> correct order across pointer wrap; base 0xFFFF + offset 2 -> location=0x0001.
- Flush mid-operation: 3 pending ops plus dispatch and CDB in the flush cycle -> next cycle count=0, input_valid=0, disp_ready=1. A later dispatch issues normally from entry 0.
